// File: rtl/sipo_reg.sv
// MSB-first serial-in, parallel-out frame receiver with held output and completion strobe.
// Latency: par_out/frame_done update on the edge sampling the last bit; clk_inh freezes all state.
module sipo_reg #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     N_clr,
  input  logic                     ser_in,
  input  logic                     clk_inh,
  input  logic                     shift_en,
  input  logic                     sync,
  output logic [WIDTH-1:0]         par_out,
  output logic                     frame_done,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] sh_q,   sh_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic [WIDTH-1:0] par_q,  par_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sh_shifted;

  assign sh_shifted = {sh_q[WIDTH-2:0], ser_in};

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    par_d  = par_q;
    done_d = 1'b0;
    if (clk_inh) begin
      // frozen: everything holds, the strobe cannot extend across an inhibit
    end else if (sync) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (shift_en) begin
      sh_d = sh_shifted;
      if (cnt_q == CNT_LAST) begin
        par_d  = sh_shifted;
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge N_clr) begin
    if (!N_clr) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      par_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      par_q  <= par_d;
      done_q <= done_d;
    end
  end

  assign par_out    = par_q;
  assign frame_done = done_q;
  assign bit_cnt    = cnt_q;

endmodule
